bsg_manycore_edge_responder: RTL and testbench
==============================================

# bsg_manycore_edge_responder

Parametrised successor to the plain per-link tie-off used on unused mesh edges of the manycore wrapper. It terminates `num_ch_p` unused edge links (W/E/N/S/IO). Each channel either silently sinks traffic or returns a well-formed response, so that a stray remote load or store never hangs the issuing tile. Every channel counts stray packets and captures the source coordinate of the first offender for host-side debug.

## Interface
Parameters:
- `num_ch_p`, 1: number of terminated edge channels.
- `addr_width_p`, 28: request word-address width.
- `data_width_p`, 32: data width.
- `x_cord_width_p`, 4: x coordinate width.
- `y_cord_width_p`, 4: y coordinate width.
- `load_id_width_p`, 5: load id width.
- `respond_mask_p`, all ones: bit i=1 means channel i responds; bit i=0 means pure sink (legacy tie-off behaviour).
- `poison_data_p`, 32'hDEAD_BEEF: data returned on load responses.
- `cnt_width_p`, 16: per-channel stray counter width, saturating.

Ports (per-channel signals are packed `[num_ch_p-1:0]` arrays of the listed width):
- `clk_i` input 1: the single clock.
- `reset_n_i` input 1: synchronous, active-low reset.
- `req_v_i` input 1: request valid.
- `req_ready_o` output 1: request ready; transfer occurs when `v & ready`.
- `req_op_i` input 2: 0 store, 1 load, 2 atomic, 3 reserved.
- `req_addr_i` input `addr_width_p`: request address (captured for debug only).
- `req_src_x_i` input `x_cord_width_p`: source x.
- `req_src_y_i` input `y_cord_width_p`: source y.
- `req_load_id_i` input `load_id_width_p`: load id.
- `resp_v_o` output 1: response valid.
- `resp_ready_i` input 1: response ready.
- `resp_type_o` output 1: 0 write credit, 1 load data.
- `resp_data_o` output `data_width_p`: response data.
- `resp_load_id_o` output `load_id_width_p`: echoed load id.
- `resp_dst_x_o` output `x_cord_width_p`: echoed request source x.
- `resp_dst_y_o` output `y_cord_width_p`: echoed request source y.
- `stray_cnt_o` output `cnt_width_p`: per-channel stray packet count.
- `err_o` output 1: sticky, set on the first stray packet.
- `first_src_x_o` output `x_cord_width_p`: x of the first offender.
- `first_src_y_o` output `y_cord_width_p`: y of the first offender.
- `first_addr_o` output `addr_width_p`: address of the first offender.
- `err_clr_i` input 1: global clear of counters, `err_o` and capture registers.

## Operation
- Channels are fully independent. The only shared input is `err_clr_i`.
- Responding channel FSM has two states, IDLE and RESP.
  - IDLE: `req_ready_o`=1, `resp_v_o`=0. An accept moves the FSM to RESP and registers the response fields.
  - RESP: `resp_v_o`=1 and all response fields are held stable until `resp_ready_i`. Then:
    - If a new request is accepted in the same cycle, stay in RESP with the new fields.
    - Otherwise go to IDLE.
  - `req_ready_o` in RESP is `resp_ready_i` (combinational), which gives back-to-back throughput of 1 packet/cycle.
- Response fields by op:
  - op 1 (load) and op 2 (atomic): `resp_type_o`=1, `resp_data_o`=`poison_data_p`.
  - op 0 (store) and op 3 (reserved): `resp_type_o`=0, `resp_data_o`=0.
  - `resp_load_id_o`, `resp_dst_x_o` and `resp_dst_y_o` always echo the request.
- Sink channel (mask bit 0): `req_ready_o`=1 permanently, `resp_v_o`=0 permanently, all `resp_*` outputs are 0.
- Counting applies on every accepted request, in both modes:
  - `stray_cnt_o` increments and saturates at all ones.
  - If `err_o`=0: set `err_o` and capture source x/y and address. Later packets do not overwrite the capture.
- `err_clr_i`=1 zeroes the counters, `err_o` and capture registers.
  - An accept in the same cycle as a clear is applied after the clear: counter=1, `err_o`=1, capture = that packet.
  - A clear does not disturb FSM state or a pending response.

## Timing
- Reset (`reset_n_i`=0 at a clock edge):
  - FSM goes to IDLE; all registers and outputs go to 0.
  - `req_ready_o`=0 while reset is asserted.
  - A response pending at reset is dropped.
- Request to response latency is 1 cycle: accept at edge N, `resp_v_o`=1 in cycle N+1.
- Counter and capture outputs update on the edge after the accept (registered).
- No combinational path from `req_v_i` to any output.
- The only combinational path is `resp_ready_i` to `req_ready_o` on responding channels in RESP.
- `resp_v_o` never deasserts without a `resp_ready_i` handshake, except under reset.

## Test plan
- Load: src (2,3), load id 5 on responding channel 0 -> one cycle later `resp_v_o`=1, type 1, data 0xDEADBEEF, id 5, dst (2,3); `stray_cnt_o`=1, `err_o`=1, first_src=(2,3).
- Backpressure: hold `resp_ready_i`=0 for 4 cycles with a second request pending -> response fields stable, `req_ready_o`=0; on release, both responses come out in order with no gap.
- Sink: channel with mask bit 0 receives 3 stores -> no `resp_v_o`, `req_ready_o` always 1, count=3, capture = first store.
- Saturation and clear: `cnt_width_p`=2, send 5 packets -> count=3. Then `err_clr_i` asserted in the same cycle as an accept -> count=1, capture = new source.
- Reset mid-response: `reset_n_i`=0 while `resp_v_o`=1 -> next cycle `resp_v_o`=0 and count=0. Traffic after reset is handled normally.
- Multi-channel: `num_ch_p`=4, simultaneous requests on all channels -> independent responses and counts, no cross-channel corruption.

Source files
------------

// File: rtl/bsg_manycore_edge_responder.sv
// ----------------------------------------------------------------------------
// bsg_manycore_edge_responder
//
// Terminates num_ch_p unused mesh edge links. Each channel is either a
// responder (returns a well-formed credit or poisoned load data so the issuing
// tile never hangs) or a pure sink (legacy tie-off). Every channel counts stray
// packets (saturating) and captures the source of the first offender.
//
// Ports (per-channel signals are packed [num_ch_p-1:0] arrays):
//   clk_i, reset_n_i     : clock, synchronous active-low reset
//   req_v_i/req_ready_o  : request handshake
//   req_op_i             : 0 store, 1 load, 2 atomic, 3 reserved
//   req_addr_i           : request word address (debug capture only)
//   req_src_x_i/_y_i     : request source coordinate
//   req_load_id_i        : load id, echoed in the response
//   resp_v_o/resp_ready_i: response handshake
//   resp_type_o          : 0 write credit, 1 load data
//   resp_data_o          : poison_data_p for load/atomic, else 0
//   resp_load_id_o, resp_dst_x_o, resp_dst_y_o : echoed request fields
//   stray_cnt_o          : saturating stray packet count
//   err_o                : sticky, set on first stray packet
//   first_src_x_o/_y_o, first_addr_o : first offender capture
//   err_clr_i            : global clear of counters, err_o and capture
// ----------------------------------------------------------------------------
module bsg_manycore_edge_responder #(
  parameter int unsigned num_ch_p        = 1,
  parameter int unsigned addr_width_p    = 28,
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned x_cord_width_p  = 4,
  parameter int unsigned y_cord_width_p  = 4,
  parameter int unsigned load_id_width_p = 5,
  parameter logic [num_ch_p-1:0]     respond_mask_p = '1,
  parameter logic [data_width_p-1:0] poison_data_p  = 32'hDEAD_BEEF,
  parameter int unsigned cnt_width_p     = 16
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic [num_ch_p-1:0]                              req_v_i,
  output logic [num_ch_p-1:0]                              req_ready_o,
  input  logic [num_ch_p-1:0][1:0]                         req_op_i,
  input  logic [num_ch_p-1:0][addr_width_p-1:0]            req_addr_i,
  input  logic [num_ch_p-1:0][x_cord_width_p-1:0]          req_src_x_i,
  input  logic [num_ch_p-1:0][y_cord_width_p-1:0]          req_src_y_i,
  input  logic [num_ch_p-1:0][load_id_width_p-1:0]         req_load_id_i,
  output logic [num_ch_p-1:0]                              resp_v_o,
  input  logic [num_ch_p-1:0]                              resp_ready_i,
  output logic [num_ch_p-1:0]                              resp_type_o,
  output logic [num_ch_p-1:0][data_width_p-1:0]            resp_data_o,
  output logic [num_ch_p-1:0][load_id_width_p-1:0]         resp_load_id_o,
  output logic [num_ch_p-1:0][x_cord_width_p-1:0]          resp_dst_x_o,
  output logic [num_ch_p-1:0][y_cord_width_p-1:0]          resp_dst_y_o,
  output logic [num_ch_p-1:0][cnt_width_p-1:0]             stray_cnt_o,
  output logic [num_ch_p-1:0]                              err_o,
  output logic [num_ch_p-1:0][x_cord_width_p-1:0]          first_src_x_o,
  output logic [num_ch_p-1:0][y_cord_width_p-1:0]          first_src_y_o,
  output logic [num_ch_p-1:0][addr_width_p-1:0]            first_addr_o,
  input  logic                                             err_clr_i
);

  localparam logic IDLE = 1'b0;
  localparam logic RESP = 1'b1;

  for (genvar i = 0; i < num_ch_p; i++) begin : g_ch

    logic accept;
    assign accept = req_v_i[i] & req_ready_o[i];

    // ------------------------------------------------------------------------
    // Stray accounting, common to responding and sink channels
    // ------------------------------------------------------------------------
    logic [cnt_width_p-1:0]    cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [x_cord_width_p-1:0] fx_q, fx_d;
    logic [y_cord_width_p-1:0] fy_q, fy_d;
    logic [addr_width_p-1:0]   fa_q, fa_d;

    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      fx_d  = fx_q;
      fy_d  = fy_q;
      fa_d  = fa_q;
      if (err_clr_i) begin
        // A same-cycle accept lands on top of the clear.
        cnt_d = cnt_width_p'(accept);
        err_d = accept;
        fx_d  = accept ? req_src_x_i[i] : '0;
        fy_d  = accept ? req_src_y_i[i] : '0;
        fa_d  = accept ? req_addr_i[i]  : '0;
      end else if (accept) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!err_q) begin
          err_d = 1'b1;
          fx_d  = req_src_x_i[i];
          fy_d  = req_src_y_i[i];
          fa_d  = req_addr_i[i];
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
        fx_q  <= '0;
        fy_q  <= '0;
        fa_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
        fx_q  <= fx_d;
        fy_q  <= fy_d;
        fa_q  <= fa_d;
      end
    end

    assign stray_cnt_o[i]   = cnt_q;
    assign err_o[i]         = err_q;
    assign first_src_x_o[i] = fx_q;
    assign first_src_y_o[i] = fy_q;
    assign first_addr_o[i]  = fa_q;

    if (respond_mask_p[i]) begin : g_resp
      // ----------------------------------------------------------------------
      // Responding channel: one-entry response register with pass-through
      // ready so back-to-back traffic flows at one packet per cycle.
      // ----------------------------------------------------------------------
      logic                       state_q, state_d;
      logic                       type_q, type_d;
      logic [data_width_p-1:0]    data_q, data_d;
      logic [load_id_width_p-1:0] id_q, id_d;
      logic [x_cord_width_p-1:0]  x_q, x_d;
      logic [y_cord_width_p-1:0]  y_q, y_d;
      logic                       is_load;

      assign is_load = (req_op_i[i] == 2'd1) || (req_op_i[i] == 2'd2);

      always_comb begin
        state_d = state_q;
        type_d  = type_q;
        data_d  = data_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        if (accept) begin
          state_d = RESP;
          type_d  = is_load;
          data_d  = is_load ? poison_data_p : '0;
          id_d    = req_load_id_i[i];
          x_d     = req_src_x_i[i];
          y_d     = req_src_y_i[i];
        end else if (state_q == RESP && resp_ready_i[i]) begin
          state_d = IDLE;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
          state_q <= IDLE;
          type_q  <= 1'b0;
          data_q  <= '0;
          id_q    <= '0;
          x_q     <= '0;
          y_q     <= '0;
        end else begin
          state_q <= state_d;
          type_q  <= type_d;
          data_q  <= data_d;
          id_q    <= id_d;
          x_q     <= x_d;
          y_q     <= y_d;
        end
      end

      // Ready is held low during reset; in RESP the slot frees exactly when
      // the current response is taken.
      assign req_ready_o[i]    = reset_n_i & ((state_q == IDLE) | resp_ready_i[i]);
      assign resp_v_o[i]       = (state_q == RESP);
      assign resp_type_o[i]    = type_q;
      assign resp_data_o[i]    = data_q;
      assign resp_load_id_o[i] = id_q;
      assign resp_dst_x_o[i]   = x_q;
      assign resp_dst_y_o[i]   = y_q;
    end else begin : g_sink
      // Legacy tie-off: swallow everything, never respond.
      assign req_ready_o[i]    = reset_n_i;
      assign resp_v_o[i]       = 1'b0;
      assign resp_type_o[i]    = 1'b0;
      assign resp_data_o[i]    = '0;
      assign resp_load_id_o[i] = '0;
      assign resp_dst_x_o[i]   = '0;
      assign resp_dst_y_o[i]   = '0;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_edge_responder.sv
// ----------------------------------------------------------------------------
// Testbench for bsg_manycore_edge_responder: four channels, channel 2 is a
// sink, 2-bit stray counters. Directed scenarios followed by random traffic.
// ----------------------------------------------------------------------------
module tb_bsg_manycore_edge_responder;

  localparam int NCH = 4;
  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int XW  = 4;
  localparam int YW  = 4;
  localparam int IW  = 5;
  localparam int CW  = 2;
  localparam logic [NCH-1:0] MASK   = 4'b1011;
  localparam logic [DW-1:0]  POISON = 32'hDEAD_BEEF;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                         clk_i = 1'b0;
  logic                         reset_n_i;
  logic [NCH-1:0]               req_v_i;
  logic [NCH-1:0]               req_ready_o;
  logic [NCH-1:0][1:0]          req_op_i;
  logic [NCH-1:0][AW-1:0]       req_addr_i;
  logic [NCH-1:0][XW-1:0]       req_src_x_i;
  logic [NCH-1:0][YW-1:0]       req_src_y_i;
  logic [NCH-1:0][IW-1:0]       req_load_id_i;
  logic [NCH-1:0]               resp_v_o;
  logic [NCH-1:0]               resp_ready_i;
  logic [NCH-1:0]               resp_type_o;
  logic [NCH-1:0][DW-1:0]       resp_data_o;
  logic [NCH-1:0][IW-1:0]       resp_load_id_o;
  logic [NCH-1:0][XW-1:0]       resp_dst_x_o;
  logic [NCH-1:0][YW-1:0]       resp_dst_y_o;
  logic [NCH-1:0][CW-1:0]       stray_cnt_o;
  logic [NCH-1:0]               err_o;
  logic [NCH-1:0][XW-1:0]       first_src_x_o;
  logic [NCH-1:0][YW-1:0]       first_src_y_o;
  logic [NCH-1:0][AW-1:0]       first_addr_o;
  logic                         err_clr_i;

  bsg_manycore_edge_responder #(
    .num_ch_p(NCH), .addr_width_p(AW), .data_width_p(DW),
    .x_cord_width_p(XW), .y_cord_width_p(YW), .load_id_width_p(IW),
    .respond_mask_p(MASK), .poison_data_p(POISON), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
    .req_load_id_i(req_load_id_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_type_o(resp_type_o),
    .resp_data_o(resp_data_o), .resp_load_id_o(resp_load_id_o),
    .resp_dst_x_o(resp_dst_x_o), .resp_dst_y_o(resp_dst_y_o),
    .stray_cnt_o(stray_cnt_o), .err_o(err_o),
    .first_src_x_o(first_src_x_o), .first_src_y_o(first_src_y_o),
    .first_addr_o(first_addr_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Checking infrastructure
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          t;
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    int            due;
  } exp_t;

  exp_t exp_q[NCH][$];

  // Reference model state
  int            cyc = 0;
  bit            busy[NCH];
  bit            pred_ready[NCH];
  bit            started = 0;
  int            m_cnt[NCH];
  bit            m_err[NCH];
  logic [XW-1:0] m_fx[NCH];
  logic [YW-1:0] m_fy[NCH];
  logic [AW-1:0] m_fa[NCH];

  // Stimulus for the next cycle
  bit            s_v[NCH], s_rr[NCH];
  logic [1:0]    s_op[NCH];
  logic [AW-1:0] s_addr[NCH];
  logic [XW-1:0] s_x[NCH];
  logic [YW-1:0] s_y[NCH];
  logic [IW-1:0] s_id[NCH];
  bit            s_clr, s_rst;

  task automatic quiet();
    for (int c = 0; c < NCH; c++) begin
      s_v[c] = 0; s_rr[c] = 1; s_op[c] = '0; s_addr[c] = '0;
      s_x[c] = '0; s_y[c] = '0; s_id[c] = '0;
    end
    s_clr = 0; s_rst = 0;
  endtask

  task automatic req(input int c, input logic [1:0] op, input logic [XW-1:0] x,
                     input logic [YW-1:0] y, input logic [IW-1:0] id,
                     input logic [AW-1:0] a);
    s_v[c] = 1; s_op[c] = op; s_x[c] = x; s_y[c] = y; s_id[c] = id; s_addr[c] = a;
  endtask

  // Applies the staged stimulus, predicts its effect, advances one clock and
  // checks the registered debug outputs. Called at posedge + 1.
  task automatic tick();
    reset_n_i = !s_rst;
    err_clr_i = s_clr;
    for (int c = 0; c < NCH; c++) begin
      req_v_i[c]       = s_v[c];
      req_op_i[c]      = s_op[c];
      req_addr_i[c]    = s_addr[c];
      req_src_x_i[c]   = s_x[c];
      req_src_y_i[c]   = s_y[c];
      req_load_id_i[c] = s_id[c];
      resp_ready_i[c]  = s_rr[c];
    end
    for (int c = 0; c < NCH; c++) begin
      bit pr, acc, ld;
      exp_t e;
      // A responder holds one response; a new request fits when the slot is
      // empty or is being drained this cycle. Sinks always accept.
      pr = !s_rst && (!MASK[c] || !busy[c] || s_rr[c]);
      pred_ready[c] = pr;
      acc = s_v[c] && pr;
      if (acc && MASK[c]) begin
        ld   = (s_op[c] == 2'd1) || (s_op[c] == 2'd2);
        e.t  = ld;
        e.d  = ld ? POISON : '0;
        e.id = s_id[c];
        e.x  = s_x[c];
        e.y  = s_y[c];
        e.due = cyc + 1;
        exp_q[c].push_back(e);
      end
      if (MASK[c]) busy[c] = acc || (busy[c] && !s_rr[c]);
      if (s_clr) begin
        m_cnt[c] = acc ? 1 : 0;
        m_err[c] = acc;
        m_fx[c]  = acc ? s_x[c] : '0;
        m_fy[c]  = acc ? s_y[c] : '0;
        m_fa[c]  = acc ? s_addr[c] : '0;
      end else if (acc) begin
        if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
        if (!m_err[c]) begin
          m_err[c] = 1; m_fx[c] = s_x[c]; m_fy[c] = s_y[c]; m_fa[c] = s_addr[c];
        end
      end
    end
    started = 1;
    @(posedge clk_i);
    #1;
    cyc++;
    if (s_rst) begin
      for (int c = 0; c < NCH; c++) begin
        exp_q[c].delete();
        busy[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
        m_fx[c] = '0; m_fy[c] = '0; m_fa[c] = '0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("cnt ch%0d", c),   64'(stray_cnt_o[c]),   64'(m_cnt[c]));
      check($sformatf("err ch%0d", c),   64'(err_o[c]),         64'(m_err[c]));
      check($sformatf("fx ch%0d", c),    64'(first_src_x_o[c]), 64'(m_fx[c]));
      check($sformatf("fy ch%0d", c),    64'(first_src_y_o[c]), 64'(m_fy[c]));
      check($sformatf("faddr ch%0d", c), 64'(first_addr_o[c]),  64'(m_fa[c]));
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: on the falling edge, compare whatever the DUT presents against
  // the head of the per-channel expectation queue; pop on handshake.
  // --------------------------------------------------------------------------
  always @(negedge clk_i) begin
    if (started) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("ready ch%0d", c), 64'(req_ready_o[c]), 64'(pred_ready[c]));
        if (reset_n_i) begin
          if (!MASK[c]) begin
            check($sformatf("sink_v ch%0d", c), 64'(resp_v_o[c]), 64'd0);
            check($sformatf("sink_fields ch%0d", c),
                  64'({resp_type_o[c], resp_data_o[c], resp_load_id_o[c],
                       resp_dst_x_o[c], resp_dst_y_o[c]}), 64'd0);
          end else begin
            bit has;
            has = (exp_q[c].size() > 0) && (exp_q[c][0].due <= cyc);
            check($sformatf("resp_v ch%0d", c), 64'(resp_v_o[c]), 64'(has));
            if (has) begin
              check($sformatf("type ch%0d", c), 64'(resp_type_o[c]),    64'(exp_q[c][0].t));
              check($sformatf("data ch%0d", c), 64'(resp_data_o[c]),    64'(exp_q[c][0].d));
              check($sformatf("id ch%0d", c),   64'(resp_load_id_o[c]), 64'(exp_q[c][0].id));
              check($sformatf("dx ch%0d", c),   64'(resp_dst_x_o[c]),   64'(exp_q[c][0].x));
              check($sformatf("dy ch%0d", c),   64'(resp_dst_y_o[c]),   64'(exp_q[c][0].y));
              if (resp_ready_i[c]) void'(exp_q[c].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset_n_i = 0; err_clr_i = 0;
    req_v_i = '0; req_op_i = '0; req_addr_i = '0; req_src_x_i = '0;
    req_src_y_i = '0; req_load_id_i = '0; resp_ready_i = '0;
    for (int c = 0; c < NCH; c++) begin
      busy[c] = 0; pred_ready[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
      m_fx[c] = '0; m_fy[c] = '0; m_fa[c] = '0;
    end
    @(posedge clk_i); #1;

    // Reset
    quiet(); s_rst = 1;
    tick(); tick();
    quiet(); tick();

    // Load on channel 0 from (2,3), id 5
    quiet(); req(0, 2'd1, 4'd2, 4'd3, 5'd5, 28'h123_4567); tick();
    quiet(); tick(); tick();

    // Backpressure on channel 1: second request waits four cycles
    quiet(); s_rr[1] = 0; req(1, 2'd2, 4'd1, 4'd1, 5'd1, 28'h0AA); tick();
    for (int k = 0; k < 4; k++) begin
      quiet(); s_rr[1] = 0; req(1, 2'd0, 4'd7, 4'd8, 5'd9, 28'h0BB); tick();
    end
    quiet(); req(1, 2'd0, 4'd7, 4'd8, 5'd9, 28'h0BB); tick();
    quiet(); tick(); tick();

    // Sink channel 2: three stores
    for (int k = 0; k < 3; k++) begin
      quiet(); req(2, 2'd0, 4'(k + 4), 4'(k + 1), 5'(k), 28'(k + 16)); tick();
    end
    quiet(); tick();

    // Saturation on channel 3, then clear coinciding with an accept
    for (int k = 0; k < 5; k++) begin
      quiet(); req(3, 2'(k), 4'd9, 4'd10, 5'(k), 28'(k + 32)); tick();
    end
    quiet(); s_clr = 1; req(3, 2'd1, 4'd12, 4'd13, 5'd3, 28'hFEED); tick();
    quiet(); tick(); tick();

    // Reset while a response is pending on channel 0
    quiet(); s_rr[0] = 0; req(0, 2'd1, 4'd5, 4'd6, 5'd7, 28'h77); tick();
    quiet(); s_rr[0] = 0; s_rst = 1; tick();
    quiet(); tick();
    quiet(); req(0, 2'd3, 4'd1, 4'd2, 5'd3, 28'h99); tick();
    quiet(); tick(); tick();

    // Simultaneous requests on all channels
    for (int k = 0; k < 3; k++) begin
      quiet();
      for (int c = 0; c < NCH; c++) req(c, 2'(c + k), 4'(c + 1), 4'(c + 2), 5'(c * 3 + k), 28'(c * 256 + k));
      tick();
    end
    quiet(); tick(); tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      quiet();
      for (int c = 0; c < NCH; c++) begin
        s_v[c]    = ($urandom_range(0, 99) < 60);
        s_rr[c]   = ($urandom_range(0, 99) < 70);
        s_op[c]   = 2'($urandom);
        s_addr[c] = AW'($urandom);
        s_x[c]    = XW'($urandom);
        s_y[c]    = YW'($urandom);
        s_id[c]   = IW'($urandom);
      end
      s_clr = ($urandom_range(0, 99) < 4);
      s_rst = ($urandom_range(0, 99) < 2);
      tick();
    end

    // Drain
    quiet();
    for (int k = 0; k < 4; k++) tick();
    for (int c = 0; c < NCH; c++)
      check($sformatf("drained ch%0d", c), 64'(exp_q[c].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
